// File: rtl/flash_store.sv
// Flash-side entry store for the password wrapper: timed program/read/erase
// with a busy/ready handshake over a retained array and per-entry valid bits.
module flash_store #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 256,
    parameter int DEPTH       = 16,
    parameter int PROG_CYCLES = 4,
    parameter int READ_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flash_write,
    input  logic [ADDR_W-1:0] add_flash,
    input  logic [DATA_W-1:0] write_data_flash,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              erase_all,
    output logic [DATA_W-1:0] data_flash,
    output logic              rd_valid,
    output logic              ready,
    output logic [ADDR_W-1:0] max_address,
    output logic [ADDR_W:0]   entry_count,
    output logic              write_err
);

    typedef enum logic [1:0] {IDLE, PROG, READ, ERASE} state_t;

    state_t            state_reg, state_next;
    logic [15:0]       cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_bits;

    logic accept_prog, accept_read;
    logic prog_done, read_done, erase_clr, erase_done, busy_err;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        accept_prog = 1'b0;
        accept_read = 1'b0;
        prog_done   = 1'b0;
        read_done   = 1'b0;
        erase_clr   = 1'b0;
        erase_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (erase_all) begin
                    state_next = ERASE;
                end else if (flash_write) begin
                    state_next  = PROG;
                    accept_prog = 1'b1;
                end else if (rd_req) begin
                    state_next  = READ;
                    accept_read = 1'b1;
                end
            end
            PROG: begin
                if (cnt_reg == 16'(PROG_CYCLES - 1)) begin
                    prog_done  = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            READ: begin
                if (cnt_reg == 16'(READ_CYCLES - 1)) begin
                    read_done  = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ERASE: begin
                erase_clr = 1'b1;
                if (cnt_reg == 16'(DEPTH - 1)) begin
                    erase_done = 1'b1;
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        busy_err = (state_reg != IDLE) && (flash_write || erase_all);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            data_flash <= '0;
            rd_valid   <= 1'b0;
            write_err  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rd_valid  <= read_done;
            if (accept_prog) begin
                addr_reg <= add_flash;
                data_reg <= write_data_flash;
            end else if (accept_read) begin
                addr_reg <= rd_addr;
            end
            if (read_done)
                data_flash <= valid_bits[addr_reg] ? mem[addr_reg] : '0;
            // Erase completion wins over a busy-time error raised on the same edge.
            if (erase_done)
                write_err <= 1'b0;
            else if (busy_err)
                write_err <= 1'b1;
        end
    end

    // Storage is non-volatile: untouched by rst. An aborted op never reaches
    // prog_done/erase_clr because the state register is already forced to IDLE.
    always_ff @(posedge clk) begin
        if (prog_done)
            mem[addr_reg] <= data_reg;
    end

    always_ff @(posedge clk) begin
        if (prog_done)
            valid_bits[addr_reg] <= 1'b1;
        if (erase_clr)
            valid_bits[cnt_reg[ADDR_W-1:0]] <= 1'b0;
    end

    always_comb begin
        entry_count = '0;
        max_address = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_count = entry_count + (ADDR_W+1)'(valid_bits[i]);
            if (valid_bits[i])
                max_address = ADDR_W'(i);
        end
    end

    assign ready = (state_reg == IDLE);

endmodule

// File: tb/tb_flash_store.sv
// Self-checking bench for flash_store: directed scenarios plus a randomized
// op stream checked against an array-based model of the stored entries.
module tb_flash_store;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flash_write = 1'b0;
    logic [3:0]   add_flash = '0;
    logic [255:0] write_data_flash = '0;
    logic         rd_req = 1'b0;
    logic [3:0]   rd_addr = '0;
    logic         erase_all = 1'b0;
    logic [255:0] data_flash;
    logic         rd_valid;
    logic         ready;
    logic [3:0]   max_address;
    logic [4:0]   entry_count;
    logic         write_err;

    int errors = 0;
    int checks = 0;

    logic [255:0] m_mem [16];
    bit           m_valid [16];

    always #5 clk = ~clk;

    flash_store dut (
        .clk(clk), .rst(rst),
        .flash_write(flash_write), .add_flash(add_flash), .write_data_flash(write_data_flash),
        .rd_req(rd_req), .rd_addr(rd_addr), .erase_all(erase_all),
        .data_flash(data_flash), .rd_valid(rd_valid), .ready(ready),
        .max_address(max_address), .entry_count(entry_count), .write_err(write_err)
    );

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic int m_max();
        int mx = 0;
        for (int i = 0; i < 16; i++) if (m_valid[i]) mx = i;
        return mx;
    endfunction

    function automatic logic [255:0] m_read(input int a);
        return m_valid[a] ? m_mem[a] : 256'd0;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Issue one command at a negedge, then count busy cycles until ready returns.
    task automatic drive_cmd(input bit e, input bit w, input bit r,
                             input logic [3:0] wa, input logic [255:0] wd, input logic [3:0] ra,
                             output int busy, output int pulses, output logic [255:0] rdata);
        @(negedge clk);
        erase_all = e; flash_write = w; rd_req = r;
        add_flash = wa; write_data_flash = wd; rd_addr = ra;
        @(posedge clk);
        #1;
        erase_all = 0; flash_write = 0; rd_req = 0;
        add_flash = ~wa; write_data_flash = ~wd; rd_addr = ~ra;
        busy = 0; pulses = 0; rdata = '0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rd_valid) begin pulses++; rdata = data_flash; end
            if (ready) break;
            busy++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_timeout: ready=%b required 1 within 64 cycles", ready);
        end
    endtask

    task automatic m_erase();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
    endtask

    task automatic m_write(input int a, input logic [255:0] d);
        m_mem[a] = d; m_valid[a] = 1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
        checks++; if (data_flash !== 256'd0) begin errors++; $display("FAIL reset_data: got %h required 0", data_flash); end
        checks++; if (write_err !== 1'b0) begin errors++; $display("FAIL reset_write_err: got %b required 0", write_err); end
        @(negedge clk); rst = 1'b1;
        $display("reset released");
    endtask

    task automatic test_erase();
        int busy, pulses; logic [255:0] rd;
        drive_cmd(1, 0, 0, 0, 0, 0, busy, pulses, rd);
        m_erase();
        $display("erase busy=%0d", busy);
        checks++; if (busy != 16) begin errors++; $display("FAIL erase_busy: got %0d required 16", busy); end
        checks++; if (entry_count !== 5'd0) begin errors++; $display("FAIL erase_count: got %0d required 0", entry_count); end
        checks++; if (max_address !== 4'd0) begin errors++; $display("FAIL erase_max: got %0d required 0", max_address); end
        checks++; if (write_err !== 1'b0) begin errors++; $display("FAIL erase_write_err: got %b required 0", write_err); end
    endtask

    task automatic test_basic();
        int busy, pulses; logic [255:0] rd; logic [255:0] a5;
        a5 = {32{8'hA5}};
        drive_cmd(0, 1, 0, 4'd3, a5, 0, busy, pulses, rd);
        m_write(3, a5);
        $display("write addr=3 busy=%0d", busy);
        checks++; if (busy != 4) begin errors++; $display("FAIL prog_busy: got %0d required 4", busy); end
        drive_cmd(0, 0, 1, 0, 0, 4'd3, busy, pulses, rd);
        $display("read addr=3 busy=%0d pulses=%0d data=%h", busy, pulses, rd);
        checks++; if (busy != 2) begin errors++; $display("FAIL read_busy: got %0d required 2", busy); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL read_pulse: got %0d required 1", pulses); end
        checks++; if (rd !== a5) begin errors++; $display("FAIL read_data3: got %h required %h", rd, a5); end
        @(negedge clk);
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_width: got %b required 0", rd_valid); end
        checks++; if (data_flash !== a5) begin errors++; $display("FAIL data_hold: got %h required %h", data_flash, a5); end
        checks++; if (entry_count !== 5'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", entry_count); end
        checks++; if (max_address !== 4'd3) begin errors++; $display("FAIL basic_max: got %0d required 3", max_address); end
    endtask

    task automatic test_multi();
        int busy, pulses; logic [255:0] rd, d7;
        int addrs [3] = '{0, 7, 15};
        test_erase();
        foreach (addrs[k]) begin
            rd = rand256();
            drive_cmd(0, 1, 0, 4'(addrs[k]), rd, 0, busy, pulses, rd);
            m_write(addrs[k], write_data_flash ^ '1);
        end
        d7 = rand256();
        drive_cmd(0, 1, 0, 4'd7, d7, 0, busy, pulses, rd);
        m_write(7, d7);
        $display("multi count=%0d max=%0d", entry_count, max_address);
        checks++; if (entry_count !== 5'(m_count())) begin errors++; $display("FAIL multi_count: got %0d required %0d", entry_count, m_count()); end
        checks++; if (max_address !== 4'(m_max())) begin errors++; $display("FAIL multi_max: got %0d required %0d", max_address, m_max()); end
        drive_cmd(0, 0, 1, 0, 0, 4'd7, busy, pulses, rd);
        checks++; if (rd !== d7) begin errors++; $display("FAIL read7_new: got %h required %h", rd, d7); end
        drive_cmd(0, 0, 1, 0, 0, 4'd9, busy, pulses, rd);
        checks++; if (rd !== 256'd0 || pulses != 1) begin errors++; $display("FAIL read9_empty: got %h pulses=%0d required 0 pulses=1", rd, pulses); end
    endtask

    task automatic test_busy_write();
        int busy, pulses; logic [255:0] rd, d1, d2;
        d1 = rand256(); d2 = rand256();
        @(negedge clk);
        flash_write = 1; add_flash = 4'd10; write_data_flash = d1;
        @(posedge clk); #1;
        flash_write = 0;
        @(negedge clk);
        flash_write = 1; add_flash = 4'd11; write_data_flash = d2;
        @(posedge clk); #1;
        flash_write = 0;
        for (int i = 0; i < 64 && !ready; i++) @(negedge clk);
        @(negedge clk);
        m_write(10, d1);
        $display("busy write: write_err=%b count=%0d", write_err, entry_count);
        checks++; if (write_err !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b required 1", write_err); end
        drive_cmd(0, 0, 1, 0, 0, 4'd10, busy, pulses, rd);
        checks++; if (rd !== m_read(10)) begin errors++; $display("FAIL busy_first_write: got %h required %h", rd, m_read(10)); end
        drive_cmd(0, 0, 1, 0, 0, 4'd11, busy, pulses, rd);
        checks++; if (rd !== m_read(11)) begin errors++; $display("FAIL busy_second_lost: got %h required %h", rd, m_read(11)); end
        checks++; if (write_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", write_err); end
        drive_cmd(1, 0, 0, 0, 0, 0, busy, pulses, rd);
        m_erase();
        checks++; if (write_err !== 1'b0) begin errors++; $display("FAIL erase_clears_err: got %b required 0", write_err); end
    endtask

    task automatic test_priority();
        int busy, pulses; logic [255:0] rd;
        drive_cmd(0, 1, 0, 4'd2, rand256(), 0, busy, pulses, rd);
        m_write(2, write_data_flash ^ '1);
        drive_cmd(1, 1, 1, 4'd4, rand256(), 4'd2, busy, pulses, rd);
        m_erase();
        $display("priority busy=%0d pulses=%0d err=%b count=%0d", busy, pulses, write_err, entry_count);
        checks++; if (busy != 16) begin errors++; $display("FAIL prio_busy: got %0d required 16", busy); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL prio_no_read: got %0d pulses required 0", pulses); end
        checks++; if (write_err !== 1'b0) begin errors++; $display("FAIL prio_no_err: got %b required 0", write_err); end
        checks++; if (entry_count !== 5'd0) begin errors++; $display("FAIL prio_count: got %0d required 0", entry_count); end
    endtask

    task automatic test_reset_abort();
        int busy, pulses, cnt_before; logic [255:0] rd, x1, x2;
        x1 = rand256(); x2 = ~x1;
        drive_cmd(0, 1, 0, 4'd5, x1, 0, busy, pulses, rd);
        m_write(5, x1);
        cnt_before = m_count();
        @(negedge clk);
        flash_write = 1; add_flash = 4'd5; write_data_flash = x2;
        @(posedge clk); #1;
        flash_write = 0;
        @(negedge clk);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b required 1", ready); end
        @(negedge clk); rst = 1'b1;
        drive_cmd(0, 0, 1, 0, 0, 4'd5, busy, pulses, rd);
        $display("abort: read5=%h count=%0d", rd, entry_count);
        checks++; if (rd !== x1) begin errors++; $display("FAIL abort_data: got %h required %h", rd, x1); end
        checks++; if (entry_count !== 5'(cnt_before)) begin errors++; $display("FAIL abort_count: got %0d required %0d", entry_count, cnt_before); end
    endtask

    task automatic test_random();
        int busy, pulses, op, a; logic [255:0] rd, d;
        for (int n = 0; n < 40; n++) begin
            op = $urandom_range(0, 11);
            a  = $urandom_range(0, 15);
            d  = rand256();
            if (op == 0) begin
                drive_cmd(1, 0, 0, 0, 0, 0, busy, pulses, rd);
                m_erase();
                $display("rand %0d erase busy=%0d", n, busy);
                checks++; if (busy != 16) begin errors++; $display("FAIL rand_erase_busy: got %0d required 16", busy); end
            end else if (op < 6) begin
                drive_cmd(0, 1, 0, 4'(a), d, 0, busy, pulses, rd);
                m_write(a, d);
                $display("rand %0d write addr=%0d busy=%0d", n, a, busy);
                checks++; if (busy != 4) begin errors++; $display("FAIL rand_prog_busy: got %0d required 4", busy); end
            end else begin
                drive_cmd(0, 0, 1, 0, 0, 4'(a), busy, pulses, rd);
                $display("rand %0d read addr=%0d data=%h", n, a, rd);
                checks++; if (rd !== m_read(a) || pulses != 1) begin errors++; $display("FAIL rand_read: addr=%0d got %h pulses=%0d required %h pulses=1", a, rd, pulses, m_read(a)); end
            end
            checks++; if (entry_count !== 5'(m_count()) || max_address !== 4'(m_max())) begin
                errors++; $display("FAIL rand_state: count=%0d max=%0d required count=%0d max=%0d", entry_count, max_address, m_count(), m_max());
            end
        end
    endtask

    initial begin
        test_reset();
        test_erase();
        test_basic();
        test_multi();
        test_busy_write();
        test_priority();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
